muldiv_unit: RTL
================

Name: muldiv_unit

Overview:
- Iterative multiply/divide controller and HI/LO register file for the 5-stage MIPS core.
- Accepts MULT/MULTU/DIV/DIVU, MTHI/MTLO and MFHI/MFLO requests from the decode stage.
- Sequences a shared shift-add / restoring-divide datapath and owns architectural HI/LO.
- Drives a stall to decode whenever a HI/LO consumer or a new muldiv op meets a busy unit.

Parameters:
- RADIX_BITS, 1, quotient/product bits retired per iteration; legal values 1, 2, 4; iterations ITERS = 32/RADIX_BITS.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  decode presents a muldiv op this cycle (qualified by its own valid, not by stall).
- op  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- rs_data  in  32  forwarded rs operand (multiplicand / dividend).
- rt_data  in  32  forwarded rt operand (multiplier / divisor).
- mthi  in  1  write rs_data to HI.
- mtlo  in  1  write rs_data to LO.
- mf_req  in  1  decode holds MFHI or MFLO.
- flush  in  1  abort in-flight op (exception/redirect).
- stall  out  1  hold decode.
- busy  out  1  FSM not IDLE.
- hi  out  32  architectural HI.
- lo  out  32  architectural LO.

Behaviour:
- Reset (async, rst_n=0): state=IDLE, hi=0, lo=0, busy=0, stall=0, iteration counter=0, operand regs=0.
- FSM states: IDLE, ITER, FIXUP.
- IDLE, start=1, edge N:
  - Latch |rs|, |rt| (magnitudes for signed ops, raw for unsigned), result-sign flags, op.
  - Clear accumulators; state=ITER, cnt=0.
- ITER: each edge retires RADIX_BITS bits; cnt++; at cnt==ITERS-1 go to FIXUP.
- FIXUP (edge N+ITERS+1):
  - Apply sign: MULT product negated if sign(rs)^sign(rt). DIV quotient negated if sign(rs)^sign(rt); remainder takes sign(rs).
  - Write HI=product[63:32]/remainder, LO=product[31:0]/quotient; state=IDLE.
- Latency: with RADIX_BITS=1, start at edge N gives HI/LO valid after edge N+33, and busy=1 for 33 cycles.
- Divide by zero (rt==0): LO=32'hFFFFFFFF, HI=rs_data as latched, no sign fixup, all ops same timing.
- 0x80000000 DIV -1: LO=0x80000000, HI=0; no trap.
- stall = busy & (start | mf_req | mthi | mtlo).
- start while busy is ignored; decode re-presents it after stall drops.
- stall is combinational, with no dependency on hi/lo.
- MTHI/MTLO when idle: register written at that edge. If start and mthi/mtlo are both asserted, start wins and the MT is ignored (illegal from decode).
- hi/lo change only at FIXUP or MT writes; mf_req reads the registered values.
- flush: in any state, state=IDLE next edge, HI/LO unchanged, in-progress result discarded. flush with start in IDLE: start ignored.
- Reset mid-operation: all state cleared immediately; HI/LO=0.

Optional Feature:
- MULDIV_EARLY_OUT_EN.
- When defined:
  - Multiply jumps ITER->FIXUP at the first edge where the remaining multiplier bits are all zero.
  - Any divide with rt==0 goes IDLE->FIXUP directly (2-cycle op).
  - Results are identical to the non-macro build.
- When undefined: always ITERS iterations; fixed latency ITERS+1.

Test Plan:
- MULT rs=0xFFFFFFFD (-3), rt=7 -> after 33 cycles HI=0xFFFFFFFF, LO=0xFFFFFFEB; busy high exactly 33 cycles.
- MULTU rs=rt=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV rs=0xFFFFFFF9 (-7), rt=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/0 -> LO=0xFFFFFFFF, HI=0x00000064.
- Issue MULT, assert mf_req at cycle 5 -> stall=1 cycles 5..32, 0 after FIXUP. Second start during busy -> ignored, stall=1.
- MULT 3*4 in flight, flush at cycle 10 -> IDLE next edge, HI/LO retain prior values (MTHI 0xAAAA0000 beforehand, still 0xAAAA0000).
- With MULDIV_EARLY_OUT_EN: MULTU 5*3 finishes in ≤4 cycles with LO=15. DIV x/0 finishes in 2 cycles. Async rst_n pulse mid-op -> hi=lo=0, busy=0 without a clock edge.

Source files
------------

// File: rtl/muldiv_unit_if.sv
// Decode-to-muldiv request/response bundle: op issue, HI/LO moves, stall and HI/LO readout.
interface muldiv_unit_if;
    logic        start;
    logic [1:0]  op;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        mthi;
    logic        mtlo;
    logic        mf_req;
    logic        flush;
    logic        stall;
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;

    modport master (
        output start, op, rs_data, rt_data, mthi, mtlo, mf_req, flush,
        input  stall, busy, hi, lo
    );

    modport slave (
        input  start, op, rs_data, rt_data, mthi, mtlo, mf_req, flush,
        output stall, busy, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative MULT/MULTU/DIV/DIVU sequencer owning architectural HI/LO.
// Define MULDIV_EARLY_OUT_EN to finish multiplies early and skip iterations on divide by zero.
module muldiv_unit #(
    parameter int unsigned RADIX_BITS = 1
) (
    input logic          clk,
    input logic          rst_n,
    muldiv_unit_if.slave bus
);
    localparam int unsigned ITERS    = 32 / RADIX_BITS;
    localparam logic [4:0]  LAST_CNT = 5'(ITERS - 1);

    typedef enum logic [1:0] {StIdle, StIter, StFixup} state_e;

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        is_div_q, is_div_d;
    logic        neg_res_q, neg_res_d;
    logic        neg_rem_q, neg_rem_d;
    logic        div0_q, div0_d;
    // mcand: shifting multiplicand, or the raw dividend kept for divide-by-zero.
    logic [63:0] mcand_q, mcand_d;
    // mplr: shifting multiplier, or the divisor magnitude.
    logic [31:0] mplr_q, mplr_d;
    // acc: product, or {remainder, dividend/quotient} during divide.
    logic [63:0] acc_q, acc_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        signed_op, rs_neg, rt_neg;
    logic [31:0] rs_mag, rt_mag;

    assign signed_op = ~bus.op[0];
    assign rs_neg    = signed_op & bus.rs_data[31];
    assign rt_neg    = signed_op & bus.rt_data[31];
    assign rs_mag    = rs_neg ? (~bus.rs_data + 32'd1) : bus.rs_data;
    assign rt_mag    = rt_neg ? (~bus.rt_data + 32'd1) : bus.rt_data;

    logic [63:0] step_acc, step_a;
    logic [31:0] step_b;
    logic [64:0] shl;

    // One iteration of shift-add multiply or restoring divide, RADIX_BITS bits wide.
    always_comb begin
        step_acc = acc_q;
        step_a   = mcand_q;
        step_b   = mplr_q;
        shl      = '0;
        for (int unsigned i = 0; i < RADIX_BITS; i++) begin
            if (is_div_q) begin
                shl = {step_acc, 1'b0};
                if (shl[64:32] >= {1'b0, mplr_q}) begin
                    shl[64:32] = shl[64:32] - {1'b0, mplr_q};
                    shl[0]     = 1'b1;
                end
                step_acc = shl[63:0];
            end else begin
                if (step_b[0]) begin
                    step_acc = step_acc + step_a;
                end
                step_a = step_a << 1;
                step_b = step_b >> 1;
            end
        end
    end

    logic [63:0] prod_fix;
    logic [31:0] fix_hi, fix_lo;

    always_comb begin
        prod_fix = neg_res_q ? (~acc_q + 64'd1) : acc_q;
        fix_hi   = prod_fix[63:32];
        fix_lo   = prod_fix[31:0];
        if (div0_q) begin
            fix_hi = mcand_q[31:0];
            fix_lo = '1;
        end else if (is_div_q) begin
            fix_hi = neg_rem_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];
            fix_lo = neg_res_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        is_div_d  = is_div_q;
        neg_res_d = neg_res_q;
        neg_rem_d = neg_rem_q;
        div0_d    = div0_q;
        mcand_d   = mcand_q;
        mplr_d    = mplr_q;
        acc_d     = acc_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    is_div_d  = bus.op[1];
                    neg_res_d = rs_neg ^ rt_neg;
                    neg_rem_d = rs_neg;
                    div0_d    = bus.op[1] & (bus.rt_data == 32'd0);
                    mcand_d   = bus.op[1] ? {32'd0, bus.rs_data} : {32'd0, rs_mag};
                    mplr_d    = rt_mag;
                    acc_d     = bus.op[1] ? {32'd0, rs_mag} : 64'd0;
                    cnt_d     = '0;
                    state_d   = StIter;
`ifdef MULDIV_EARLY_OUT_EN
                    if (bus.op[1] && (bus.rt_data == 32'd0)) begin
                        state_d = StFixup;
                    end
`endif
                end else begin
                    if (bus.mthi) hi_d = bus.rs_data;
                    if (bus.mtlo) lo_d = bus.rs_data;
                end
            end
            StIter: begin
                acc_d   = step_acc;
                mcand_d = step_a;
                mplr_d  = step_b;
                cnt_d   = cnt_q + 5'd1;
                if (cnt_q == LAST_CNT) begin
                    state_d = StFixup;
                end
`ifdef MULDIV_EARLY_OUT_EN
                if (!is_div_q && (step_b == 32'd0)) begin
                    state_d = StFixup;
                end
`endif
            end
            StFixup: begin
                hi_d    = fix_hi;
                lo_d    = fix_lo;
                cnt_d   = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Flush aborts everything, including a pending start or MT write.
        if (bus.flush) begin
            state_d = StIdle;
            cnt_d   = '0;
            hi_d    = hi_q;
            lo_d    = lo_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            neg_res_q <= 1'b0;
            neg_rem_q <= 1'b0;
            div0_q    <= 1'b0;
            mcand_q   <= '0;
            mplr_q    <= '0;
            acc_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            is_div_q  <= is_div_d;
            neg_res_q <= neg_res_d;
            neg_rem_q <= neg_rem_d;
            div0_q    <= div0_d;
            mcand_q   <= mcand_d;
            mplr_q    <= mplr_d;
            acc_q     <= acc_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign bus.busy  = (state_q != StIdle);
    assign bus.stall = bus.busy & (bus.start | bus.mf_req | bus.mthi | bus.mtlo);
    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
endmodule
